// File: rtl/gcd_stream_if.sv
// Valid/ready operand and result channel for the GCD stream engine.
// The producer/consumer side uses master; the engine uses slave.
interface gcd_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             error;
  logic [WIDTH-1:0] iter;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, error, iter, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, error, iter, busy
  );
endinterface

// File: rtl/gcd_stream_engine.sv
// Handshaked subtract-and-compare GCD engine, one subtraction per cycle,
// with zero-operand shortcuts, an iteration budget and output backpressure.
module gcd_stream_engine #(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 2**WIDTH - 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  gcd_stream_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] LP_MAX_ITER = WIDTH'(MAX_ITER);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_iter;
  logic             r_error;

  logic w_accept;
  logic w_a_zero;
  logic w_b_zero;
  logic w_equal;
  logic w_timeout;
  logic w_a_gt_b;

  assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
  assign w_a_zero  = (bus.a == '0);
  assign w_b_zero  = (bus.b == '0);
  assign w_equal   = (r_a == r_b);
  assign w_timeout = (r_count == LP_MAX_ITER);
  assign w_a_gt_b  = (r_a > r_b);

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = (w_a_zero || w_b_zero) ? S_DONE : S_CALC;
      S_CALC: if (w_equal || w_timeout) w_next_state = S_DONE;
      S_DONE: if (bus.out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_count <= '0;
      r_y     <= '0;
      r_iter  <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_a_zero || w_b_zero) begin
              // With at least one operand zero, OR yields the other one.
              r_y     <= bus.a | bus.b;
              r_error <= w_a_zero && w_b_zero;
              r_iter  <= '0;
            end else begin
              r_a     <= bus.a;
              r_b     <= bus.b;
              r_count <= '0;
            end
          end
        end
        S_CALC: begin
          if (w_equal) begin
            r_y     <= r_a;
            r_error <= 1'b0;
            r_iter  <= r_count;
          end else if (w_timeout) begin
            r_y     <= '0;
            r_error <= 1'b1;
            r_iter  <= r_count;
          end else if (w_a_gt_b) begin
            r_a     <= r_a - r_b;
            r_count <= r_count + 1'b1;
          end else begin
            r_b     <= r_b - r_a;
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_CALC);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.y         = r_y;
  assign bus.error     = r_error;
  assign bus.iter      = r_iter;

endmodule

// File: tb/tb_gcd_stream_engine.sv
// Scoreboard bench for gcd_stream_engine: default 8-bit, 8-bit with a
// 4-step budget, and 16-bit instances checked against a Euclid-based model.
module tb_gcd_stream_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_stream_if #(.WIDTH(8))  bus8  ();
  gcd_stream_if #(.WIDTH(8))  bust  ();
  gcd_stream_if #(.WIDTH(16)) bus16 ();

  gcd_stream_engine #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .bus(bus8.slave)
  );
  gcd_stream_engine #(.WIDTH(8), .MAX_ITER(4)) u_dut_to (
    .i_clk(clk), .i_rst(rst), .bus(bust.slave)
  );
  gcd_stream_engine #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .bus(bus16.slave)
  );

  typedef struct packed {
    logic [15:0] y;
    logic        err;
    logic [15:0] iter;
  } exp_t;

  exp_t sb8[$];
  exp_t sbt[$];
  exp_t sb16[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Subtraction count = sum of Euclid quotients minus one.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int unsigned max_iter);
    exp_t        e;
    int unsigned x, y, t, steps;
    e = '0;
    if (a == 0 && b == 0) begin
      e.err = 1'b1;
      return e;
    end
    if (a == 0 || b == 0) begin
      e.y = 16'(a | b);
      return e;
    end
    x = a; y = b; steps = 0;
    while (y != 0) begin
      steps += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    steps -= 1;
    if (steps > max_iter) begin
      e.err  = 1'b1;
      e.iter = 16'(max_iter);
    end else begin
      e.y    = 16'(x);
      e.iter = 16'(steps);
    end
    return e;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    while (!bus8.in_ready && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (bus8.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send8_ready: in_ready=%b required 1", bus8.in_ready);
    end
    bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
    sb8.push_back(model(a, b, 255));
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic recv8(input int stall, output int cycles);
    exp_t e;
    cycles = 0;
    while (!bus8.out_valid && cycles < 2000) begin
      @(posedge clk); #1; cycles++;
    end
    n_cmp++;
    if (bus8.out_valid !== 1'b1 || sb8.size() == 0) begin
      n_bad++;
      $display("FAIL recv8_valid: out_valid=%b queued=%0d required 1 and >0", bus8.out_valid, sb8.size());
      return;
    end
    repeat (stall) begin @(posedge clk); #1; end
    e = sb8.pop_front();
    n_cmp += 3;
    if (bus8.y !== e.y[7:0]) begin
      n_bad++; $display("FAIL recv8_y: got %0d required %0d", bus8.y, e.y[7:0]);
    end
    if (bus8.error !== e.err) begin
      n_bad++; $display("FAIL recv8_error: got %b required %b", bus8.error, e.err);
    end
    if (bus8.iter !== e.iter[7:0]) begin
      n_bad++; $display("FAIL recv8_iter: got %0d required %0d", bus8.iter, e.iter[7:0]);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus8.in_valid = 0;  bus8.a = 0;  bus8.b = 0;  bus8.out_ready = 0;
    bust.in_valid = 0;  bust.a = 0;  bust.b = 0;  bust.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.out_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp += 6;
    if (bus8.in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", bus8.in_ready); end
    if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", bus8.out_valid); end
    if (bus8.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus8.busy); end
    if (bus8.y !== 8'd0)         begin n_bad++; $display("FAIL reset_y: got %0d required 0", bus8.y); end
    if (bus8.error !== 1'b0)     begin n_bad++; $display("FAIL reset_error: got %b required 0", bus8.error); end
    if (bus8.iter !== 8'd0)      begin n_bad++; $display("FAIL reset_iter: got %0d required 0", bus8.iter); end
  endtask

  task automatic test_basic;
    int cyc;
    send8(8'd12, 8'd18);
    n_cmp += 2;
    if (bus8.busy !== 1'b1)     begin n_bad++; $display("FAIL basic_busy: got %b required 1", bus8.busy); end
    if (bus8.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_calc: got %b required 0", bus8.in_ready); end
    recv8(0, cyc);
    n_cmp += 2;
    if (cyc !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d required 3", cyc); end
    if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_after: got %b required 1", bus8.in_ready); end
  endtask

  task automatic test_zero;
    int cyc;
    send8(8'd0, 8'd45);
    recv8(0, cyc);
    n_cmp++;
    if (cyc !== 0) begin n_bad++; $display("FAIL zero_latency_b: got %0d required 0", cyc); end
    send8(8'd0, 8'd0);
    recv8(0, cyc);
    n_cmp++;
    if (cyc !== 0) begin n_bad++; $display("FAIL zero_latency_both: got %0d required 0", cyc); end
    send8(8'd37, 8'd0);
    recv8(0, cyc);
  endtask

  task automatic test_timeout;
    int   cyc = 0;
    exp_t e;
    bust.a = 8'd1; bust.b = 8'd255; bust.in_valid = 1'b1;
    sbt.push_back(model(1, 255, 4));
    @(posedge clk); #1;
    bust.in_valid = 1'b0;
    while (!bust.out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    e = sbt.pop_front();
    n_cmp += 4;
    if (cyc !== 5)               begin n_bad++; $display("FAIL timeout_latency: got %0d required 5", cyc); end
    if (bust.y !== e.y[7:0])     begin n_bad++; $display("FAIL timeout_y: got %0d required %0d", bust.y, e.y[7:0]); end
    if (bust.error !== e.err)    begin n_bad++; $display("FAIL timeout_error: got %b required %b", bust.error, e.err); end
    if (bust.iter !== e.iter[7:0]) begin n_bad++; $display("FAIL timeout_iter: got %0d required %0d", bust.iter, e.iter[7:0]); end
    bust.out_ready = 1'b1;
    @(posedge clk); #1;
    bust.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int   cyc;
    exp_t e;
    send8(8'd100, 8'd75);
    e = sb8[0];
    cyc = 0;
    while (!bus8.out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp += 4;
      if (bus8.out_valid !== 1'b1)  begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b required 1", i, bus8.out_valid); end
      if (bus8.y !== e.y[7:0])      begin n_bad++; $display("FAIL bp_y[%0d]: got %0d required %0d", i, bus8.y, e.y[7:0]); end
      if (bus8.iter !== e.iter[7:0]) begin n_bad++; $display("FAIL bp_iter[%0d]: got %0d required %0d", i, bus8.iter, e.iter[7:0]); end
      if (bus8.in_ready !== 1'b0)   begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, bus8.in_ready); end
      bus8.a = 8'd9; bus8.b = 8'd3;
      bus8.in_valid = (i >= 2 && i <= 5);
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    recv8(0, cyc);
    n_cmp += 2;
    if (bus8.in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_release_in_ready: got %b required 1", bus8.in_ready); end
    if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b required 0", bus8.out_valid); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_stall_pulse_accepted: out_valid=%b required 0", bus8.out_valid); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    send8(8'd1, 8'd200);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb8.delete();
    n_cmp += 5;
    if (bus8.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b required 0", bus8.out_valid); end
    if (bus8.y !== 8'd0)         begin n_bad++; $display("FAIL rstmid_y: got %0d required 0", bus8.y); end
    if (bus8.iter !== 8'd0)      begin n_bad++; $display("FAIL rstmid_iter: got %0d required 0", bus8.iter); end
    if (bus8.in_ready !== 1'b1)  begin n_bad++; $display("FAIL rstmid_in_ready: got %b required 1", bus8.in_ready); end
    if (bus8.busy !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy: got %b required 0", bus8.busy); end
    send8(8'd21, 8'd14);
    recv8(0, cyc);
  endtask

  task automatic test_back_to_back;
    logic [7:0] pa [8];
    logic [7:0] pb [8];
    pa[0] = 8'd1;   pb[0] = 8'd255;
    pa[1] = 8'd255; pb[1] = 8'd255;
    pa[2] = 8'd128; pb[2] = 8'd96;
    pa[3] = 8'd17;  pb[3] = 8'd0;
    for (int i = 4; i < 8; i++) begin
      pa[i] = 8'($urandom_range(1, 255));
      pb[i] = 8'($urandom_range(1, 255));
    end
    fork
      begin
        for (int i = 0; i < 8; i++) send8(pa[i], pb[i]);
      end
      begin
        int cyc;
        for (int j = 0; j < 8; j++) recv8(int'($urandom_range(0, 3)), cyc);
      end
    join
    n_cmp++;
    if (sb8.size() !== 0) begin n_bad++; $display("FAIL b2b_leftover: got %0d required 0", sb8.size()); end
  endtask

  task automatic test_wide;
    logic [15:0] av [2];
    logic [15:0] bv [2];
    int          cyc;
    exp_t        e;
    av[0] = 16'd65535; bv[0] = 16'd1;
    av[1] = 16'd48000; bv[1] = 16'd36000;
    for (int i = 0; i < 2; i++) begin
      bus16.a = av[i]; bus16.b = bv[i]; bus16.in_valid = 1'b1;
      sb16.push_back(model(av[i], bv[i], 65535));
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      cyc = 0;
      while (!bus16.out_valid && cyc < 70000) begin
        @(posedge clk); #1; cyc++;
      end
      e = sb16.pop_front();
      n_cmp += 4;
      if (cyc !== int'(e.iter) + 1) begin n_bad++; $display("FAIL wide_latency[%0d]: got %0d required %0d", i, cyc, int'(e.iter) + 1); end
      if (bus16.y !== e.y)        begin n_bad++; $display("FAIL wide_y[%0d]: got %0d required %0d", i, bus16.y, e.y); end
      if (bus16.error !== e.err)  begin n_bad++; $display("FAIL wide_error[%0d]: got %b required %b", i, bus16.error, e.err); end
      if (bus16.iter !== e.iter)  begin n_bad++; $display("FAIL wide_iter[%0d]: got %0d required %0d", i, bus16.iter, e.iter); end
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
